// File: rtl/iob_regpipe_ibex_pkg.sv
// Shared defaults for the iob_regpipe_ibex pipeline register chain.
package iob_regpipe_ibex_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_DEPTH   = 2;
  localparam int unsigned DEF_RST_VAL = 0;
  localparam int unsigned MAX_DEPTH   = 16;

endpackage

// File: rtl/iob_regpipe_stage_ibex.sv
// One valid/data stage of the register pipeline with reset > flush > load priority.
module iob_regpipe_stage_ibex
  import iob_regpipe_ibex_pkg::*;
#(
  parameter int unsigned       DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(DEF_RST_VAL)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              src_valid_i,
  input  logic [DATA_W-1:0] src_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  // Data is only written with a valid source word so bubbles never toggle it.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_o <= 1'b0;
      data_o  <= RST_VAL;
    end else if (load_i) begin
      valid_o <= src_valid_i;
      if (src_valid_i) begin
        data_o <= src_data_i;
      end
    end
  end

endmodule

// File: rtl/iob_regpipe_ibex.sv
// DEPTH-stage valid/ready register pipeline with flush, clock enable and occupancy count.
module iob_regpipe_ibex
  import iob_regpipe_ibex_pkg::*;
#(
  parameter int unsigned       DATA_W  = DEF_DATA_W,
  parameter int unsigned       DEPTH   = DEF_DEPTH,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(DEF_RST_VAL),
  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  level_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  src_valid;
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [DATA_W-1:0] src_data [DEPTH];
  logic              clr;
  logic              run;
  logic              in_xfer;
  logic              out_xfer;
  logic [CNT_W-1:0]  level_q;

  assign clr = rst_i | flush_i;
  assign run = cke_i & ~clr;

  // A stage may advance if it is empty or everything downstream of it can move.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = ~valid_q[DEPTH-1] | out_ready_i;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      adv[k] = ~valid_q[k] | adv[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_src_in
      assign src_valid[k] = in_valid_i;
      assign src_data[k]  = in_data_i;
    end else begin : g_src_prev
      assign src_valid[k] = valid_q[k-1];
      assign src_data[k]  = data_q[k-1];
    end

    iob_regpipe_stage_ibex #(
      .DATA_W (DATA_W),
      .RST_VAL(RST_VAL)
    ) u_stage (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .load_i     (run & adv[k]),
      .src_valid_i(src_valid[k]),
      .src_data_i (src_data[k]),
      .valid_o    (valid_q[k]),
      .data_o     (data_q[k])
    );
  end

  assign in_ready_o  = run & adv[0];
  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = valid_q[DEPTH-1] & out_ready_i & run;

  // Occupancy tracks transfers on the same edge as the stages.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      level_q <= '0;
    end else begin
      level_q <= level_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end
  end

  assign level_o = level_q;

endmodule

// File: tb/tb_iob_regpipe_ibex.sv
// Scoreboard bench: DEPTH 3 directed sequence plus random traffic on DEPTH 1, 4 and 16.
module tb_iob_regpipe_ibex;

  localparam int unsigned NI      = 4;
  localparam int unsigned NCYC    = 10000;
  localparam logic [7:0]  RST_VAL = 8'hE5;

  typedef struct {
    logic [7:0]  d;
    int unsigned t;
  } word_t;

  function automatic int unsigned dep_of(input int g);
    case (g)
      0:       return 3;
      1:       return 1;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  logic clk;
  int   n_chk;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned D  = dep_of(g);
    localparam int unsigned CW = $clog2(D + 1);

    logic          rst, cke, flush, in_valid, out_ready;
    logic [7:0]    in_data;
    logic          in_ready, out_valid;
    logic [7:0]    out_data;
    logic [CW-1:0] lvl;
    bit            mon_en = 1'b0;
    bit            done   = 1'b0;

    iob_regpipe_ibex #(
      .DATA_W (8),
      .DEPTH  (D),
      .RST_VAL(RST_VAL)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .cke_i      (cke),
      .flush_i    (flush),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (in_data),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .level_o    (lvl)
    );

    // Reference model: an ordered queue of accepted words stamped with the
    // enabled-edge count at acceptance; a word is visible at the output once
    // it has been in flight for DEPTH-1 further enabled edges.
    word_t       q[$];
    int unsigned tick     = 0;
    logic [7:0]  last_out = RST_VAL;

    always @(negedge clk) begin
      bit         rdy_m;
      bit         ov_m;
      logic [7:0] od_m;
      if (mon_en) begin
        rdy_m = cke && !flush && !rst && (q.size() < D || out_ready);
        ov_m  = (q.size() > 0) && ((tick - q[0].t) >= D - 1);
        od_m  = ov_m ? q[0].d : last_out;
        chk($sformatf("d%0d in_ready", D), 32'(in_ready), 32'(rdy_m));
        chk($sformatf("d%0d level", D), 32'(lvl), 32'(q.size()));
        chk($sformatf("d%0d out_valid", D), 32'(out_valid), 32'(ov_m));
        chk($sformatf("d%0d out_data", D), 32'(out_data), 32'(od_m));
        if (rst || flush) begin
          q.delete();
          last_out = RST_VAL;
        end else if (cke) begin
          if (ov_m && out_ready) begin
            last_out = q[0].d;
            void'(q.pop_front());
          end
          tick++;
          if (in_valid && rdy_m) begin
            q.push_back('{d: in_data, t: tick});
          end
        end
      end
    end

    if (g == 0) begin : g_directed
      task automatic exp(input string nm, input logic rdy, input int lv,
                         input logic ov, input logic [7:0] od);
        #1;
        chk({nm, " in_ready"}, 32'(in_ready), 32'(rdy));
        chk({nm, " level"}, 32'(lvl), 32'(lv));
        chk({nm, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({nm, " out_data"}, 32'(out_data), 32'(od));
      endtask

      initial begin
        rst = 1'b1; cke = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        step();
        mon_en = 1'b1;
        rst = 1'b0;
        exp("reset", 1'b1, 0, 1'b0, RST_VAL);
        // back-to-back with open output
        in_valid = 1'b1; in_data = 8'h11; exp("b2b_c0", 1'b1, 0, 1'b0, RST_VAL);
        step(); in_data = 8'h22; exp("b2b_c1", 1'b1, 1, 1'b0, RST_VAL);
        step(); in_data = 8'h33; exp("b2b_c2", 1'b1, 2, 1'b0, RST_VAL);
        step(); in_valid = 1'b0; exp("b2b_c3", 1'b1, 3, 1'b1, 8'h11);
        step(); exp("b2b_c4", 1'b1, 2, 1'b1, 8'h22);
        step(); exp("b2b_c5", 1'b1, 1, 1'b1, 8'h33);
        step(); exp("b2b_c6", 1'b1, 0, 1'b0, 8'h33);
        // stall then drain
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11; exp("stall_0", 1'b1, 0, 1'b0, 8'h33);
        step(); in_data = 8'h22; exp("stall_1", 1'b1, 1, 1'b0, 8'h33);
        step(); in_data = 8'h33; exp("stall_2", 1'b1, 2, 1'b0, 8'h33);
        step(); in_data = 8'h44; exp("stall_full", 1'b0, 3, 1'b1, 8'h11);
        step(); exp("stall_hold", 1'b0, 3, 1'b1, 8'h11);
        step(); out_ready = 1'b1; exp("drain_rdy", 1'b1, 3, 1'b1, 8'h11);
        step(); in_valid = 1'b0; exp("drain_1", 1'b1, 3, 1'b1, 8'h22);
        step(); exp("drain_2", 1'b1, 2, 1'b1, 8'h33);
        step(); exp("drain_3", 1'b1, 1, 1'b1, 8'h44);
        step(); exp("drain_4", 1'b1, 0, 1'b0, 8'h44);
        // bubble collapse
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1; exp("bub_0", 1'b1, 0, 1'b0, 8'h44);
        step(); in_valid = 1'b0; exp("bub_1", 1'b1, 1, 1'b0, 8'h44);
        step(); exp("bub_2", 1'b1, 1, 1'b0, 8'h44);
        step(); in_valid = 1'b1; in_data = 8'hA2; exp("bub_3", 1'b1, 1, 1'b1, 8'hA1);
        step(); in_valid = 1'b0; exp("bub_4", 1'b1, 2, 1'b1, 8'hA1);
        step(); exp("bub_5", 1'b1, 2, 1'b1, 8'hA1);
        step(); exp("bub_6", 1'b1, 2, 1'b1, 8'hA1);
        // flush with a word offered
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h55; exp("flush_req", 1'b0, 2, 1'b1, 8'hA1);
        step(); flush = 1'b0; in_valid = 1'b0; exp("flush_done", 1'b1, 0, 1'b0, RST_VAL);
        step(); exp("flush_after", 1'b1, 0, 1'b0, RST_VAL);
        // clock-enable freeze and reset while frozen
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h61; exp("cke_0", 1'b1, 0, 1'b0, RST_VAL);
        step(); in_data = 8'h62; exp("cke_1", 1'b1, 1, 1'b0, RST_VAL);
        step(); in_data = 8'h63; exp("cke_2", 1'b1, 2, 1'b0, RST_VAL);
        step(); cke = 1'b0; in_data = 8'h64; exp("cke_off", 1'b0, 3, 1'b1, 8'h61);
        for (int i = 0; i < 5; i++) begin
          step(); exp("cke_frozen", 1'b0, 3, 1'b1, 8'h61);
        end
        rst = 1'b1; exp("rst_frozen", 1'b0, 3, 1'b1, 8'h61);
        step(); rst = 1'b0; exp("rst_taken", 1'b0, 0, 1'b0, RST_VAL);
        cke = 1'b1; in_valid = 1'b0; exp("cke_back", 1'b1, 0, 1'b0, RST_VAL);
        step();
        done = 1'b1;
      end
    end else begin : g_random
      initial begin
        rst = 1'b1; cke = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        step();
        mon_en = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < NCYC; i++) begin
          in_valid  = ($urandom_range(0, 3) != 0);
          in_data   = 8'($urandom);
          out_ready = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                           : ($urandom_range(0, 3) == 0);
          cke       = ($urandom_range(0, 15) != 0);
          flush     = ($urandom_range(0, 127) == 0);
          rst       = ($urandom_range(0, 999) == 0);
          step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        done = 1'b1;
      end
    end
  end

  initial begin
    bit all_done;
    n_chk  = 0;
    n_fail = 0;
    all_done = 1'b0;
    for (int i = 0; i < 30000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done;
    end
    n_chk++;
    if (!all_done) begin
      n_fail++;
      $display("FAIL timeout: stimulus did not complete, got done=0 expected done=1");
    end
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
